// File: rtl/dds_pkg.sv
// Shared types and default widths for the time-multiplexed wavetable DDS voice engine.
package dds_pkg;

  localparam int unsigned DDS_P_WIDTH  = 32;
  localparam int unsigned DDS_D_WIDTH  = 16;
  localparam int unsigned DDS_A_WIDTH  = 12;
  localparam int unsigned DDS_F_WIDTH  = 16;
  localparam int unsigned DDS_E_WIDTH  = 16;
  localparam int unsigned DDS_N_VOICES = 8;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR1,
    CAP,
    CALC,
    EMIT
  } dds_state_t;

  typedef struct packed {
    logic [DDS_P_WIDTH-1:0] freq;
    logic [DDS_P_WIDTH-1:0] phaseOffset;
    logic [DDS_E_WIDTH-1:0] env;
    logic                   gate;
    logic                   fmEn;
  } voice_cfg_t;

endpackage

// File: rtl/dds_lerp_env.sv
// Combinational linear interpolation between two signed samples followed by
// an unsigned envelope multiply; floor (arithmetic-shift) rounding throughout.
module dds_lerp_env
  import dds_pkg::*;
#(
  parameter int unsigned D_WIDTH = DDS_D_WIDTH,
  parameter int unsigned F_WIDTH = DDS_F_WIDTH,
  parameter int unsigned E_WIDTH = DDS_E_WIDTH
) (
  input  logic [D_WIDTH-1:0] s0,
  input  logic [D_WIDTH-1:0] s1,
  input  logic [F_WIDTH-1:0] frac,
  input  logic [E_WIDTH-1:0] env,
  input  logic               gate,
  output logic [D_WIDTH-1:0] out
);

  localparam int unsigned DW = D_WIDTH + F_WIDTH + 2;
  localparam int unsigned EW = D_WIDTH + E_WIDTH + 1;

  logic signed [D_WIDTH:0]   diff;
  logic signed [DW-1:0]      diff_x;
  logic signed [DW-1:0]      frac_x;
  logic signed [DW-1:0]      dprod;
  logic signed [D_WIDTH-1:0] lerp;
  logic signed [EW-1:0]      lerp_x;
  logic signed [EW-1:0]      env_x;
  logic signed [EW-1:0]      eprod;
  logic                      unused_prod_bits;

  // The interpolated value always lies between s0 and s1, so only the low
  // D_WIDTH bits of the shifted product term are needed for the modular sum.
  always_comb begin
    diff   = $signed({s1[D_WIDTH-1], s1}) - $signed({s0[D_WIDTH-1], s0});
    diff_x = DW'(diff);
    frac_x = DW'(frac);
    dprod  = diff_x * frac_x;
    lerp   = s0 + dprod[F_WIDTH +: D_WIDTH];
    lerp_x = EW'(lerp);
    env_x  = EW'(env);
    eprod  = lerp_x * env_x;
    out    = gate ? eprod[E_WIDTH +: D_WIDTH] : '0;
  end

  assign unused_prod_bits = ^{dprod, eprod};

endmodule

// File: rtl/dds_voice_engine.sv
// N-voice time-multiplexed wavetable DDS: 5 cycles per voice, one output beat per voice.
// Define DDS_FM_CHAIN_EN to let voice v phase-modulate from voice v-1's output.
module dds_voice_engine
  import dds_pkg::*;
#(
  parameter int unsigned P_WIDTH  = DDS_P_WIDTH,
  parameter int unsigned D_WIDTH  = DDS_D_WIDTH,
  parameter int unsigned A_WIDTH  = DDS_A_WIDTH,
  parameter int unsigned F_WIDTH  = DDS_F_WIDTH,
  parameter int unsigned E_WIDTH  = DDS_E_WIDTH,
  parameter int unsigned N_VOICES = DDS_N_VOICES,
  parameter int unsigned V_WIDTH  = $clog2(N_VOICES)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               sampleTick,
  input  logic               cfgWe,
  input  logic [V_WIDTH-1:0] cfgVoice,
  input  logic [P_WIDTH-1:0] cfgFreq,
  input  logic [P_WIDTH-1:0] cfgPhaseOffset,
  input  logic [E_WIDTH-1:0] cfgEnv,
  input  logic               cfgGate,
  input  logic               cfgFmEn,
  output logic [A_WIDTH-1:0] tblAddr,
  output logic               tblRdEn,
  input  logic [D_WIDTH-1:0] tblData,
  output logic [D_WIDTH-1:0] voiceOut,
  output logic [V_WIDTH-1:0] voiceIdx,
  output logic               voiceValid,
  output logic               frameDone,
  output logic               busy,
  output logic               overrun
);

  logic [P_WIDTH-1:0]  freq_q [N_VOICES];
  logic [P_WIDTH-1:0]  poff_q [N_VOICES];
  logic [E_WIDTH-1:0]  env_q  [N_VOICES];
  logic [P_WIDTH-1:0]  acc_q  [N_VOICES];
  logic [N_VOICES-1:0] gate_q;
  logic [N_VOICES-1:0] fmen_q;

  dds_state_t          state_q, state_d;
  logic [V_WIDTH-1:0]  voice_q;
  logic [A_WIDTH-1:0]  addr_q;
  logic [F_WIDTH-1:0]  frac_q;
  logic [P_WIDTH-1:0]  wfreq_q;
  logic [E_WIDTH-1:0]  wenv_q;
  logic                wgate_q;
  logic [D_WIDTH-1:0]  s0_q, s1_q, out_q;
  logic [D_WIDTH-1:0]  lerp_out;
  logic                overrun_q;
  logic [P_WIDTH-1:0]  phase;
  logic                last_voice;
  logic                unused_bits;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < N_VOICES; i++) begin
        freq_q[i] <= '0;
        poff_q[i] <= '0;
        env_q[i]  <= '0;
      end
      gate_q <= '0;
      fmen_q <= '0;
    end else if (cfgWe) begin
      // Out-of-range voice indices match no entry and are dropped.
      for (int unsigned i = 0; i < N_VOICES; i++) begin
        if (cfgVoice == V_WIDTH'(i)) begin
          freq_q[i] <= cfgFreq;
          poff_q[i] <= cfgPhaseOffset;
          env_q[i]  <= cfgEnv;
          gate_q[i] <= cfgGate;
          fmen_q[i] <= cfgFmEn;
        end
      end
    end
  end

  always_comb begin
    phase = acc_q[voice_q] + poff_q[voice_q];
`ifdef DDS_FM_CHAIN_EN
    if ((voice_q != '0) && fmen_q[voice_q])
      phase = phase + {out_q, {(P_WIDTH-D_WIDTH){1'b0}}};
`endif
  end

  assign unused_bits = ^{phase, fmen_q};
  assign last_voice  = (voice_q == V_WIDTH'(N_VOICES - 1));

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    tblAddr    = '0;
    tblRdEn    = 1'b0;
    voiceValid = 1'b0;
    frameDone  = 1'b0;
    unique case (state_q)
      IDLE:  if (sampleTick) state_d = ADDR;
      ADDR: begin
        tblAddr = phase[P_WIDTH-1 -: A_WIDTH];
        tblRdEn = 1'b1;
        state_d = ADDR1;
      end
      ADDR1: begin
        tblAddr = addr_q + A_WIDTH'(1);
        tblRdEn = 1'b1;
        state_d = CAP;
      end
      CAP:   state_d = CALC;
      CALC:  state_d = EMIT;
      EMIT: begin
        voiceValid = 1'b1;
        frameDone  = last_voice;
        state_d    = last_voice ? IDLE : ADDR;
      end
      default: state_d = IDLE;
    endcase
  end

  dds_lerp_env #(
    .D_WIDTH(D_WIDTH),
    .F_WIDTH(F_WIDTH),
    .E_WIDTH(E_WIDTH)
  ) u_lerp_env (
    .s0  (s0_q),
    .s1  (s1_q),
    .frac(frac_q),
    .env (wenv_q),
    .gate(wgate_q),
    .out (lerp_out)
  );

  // Working copies are latched in ADDR so config writes never disturb a voice in flight.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < N_VOICES; i++) acc_q[i] <= '0;
      voice_q   <= '0;
      addr_q    <= '0;
      frac_q    <= '0;
      wfreq_q   <= '0;
      wenv_q    <= '0;
      wgate_q   <= 1'b0;
      s0_q      <= '0;
      s1_q      <= '0;
      out_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (sampleTick && (state_q != IDLE)) overrun_q <= 1'b1;
      case (state_q)
        IDLE: if (sampleTick) voice_q <= '0;
        ADDR: begin
          addr_q  <= phase[P_WIDTH-1 -: A_WIDTH];
          frac_q  <= phase[P_WIDTH-A_WIDTH-1 -: F_WIDTH];
          wfreq_q <= freq_q[voice_q];
          wenv_q  <= env_q[voice_q];
          wgate_q <= gate_q[voice_q];
        end
        ADDR1: s0_q  <= tblData;
        CAP:   s1_q  <= tblData;
        CALC:  out_q <= lerp_out;
        EMIT: begin
          acc_q[voice_q] <= wgate_q ? (acc_q[voice_q] + wfreq_q) : '0;
          if (!last_voice) voice_q <= voice_q + V_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state_q != IDLE);
  assign voiceOut = out_q;
  assign voiceIdx = voice_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_dds_voice_engine.sv
// Directed + randomized bench for dds_voice_engine against a frame-level arithmetic model.
module tb_dds_voice_engine;
  import dds_pkg::*;

  localparam int NV = 8;

  logic        Clk = 1'b0;
  logic        Reset, sampleTick, cfgWe, cfgGate, cfgFmEn;
  logic [2:0]  cfgVoice;
  logic [31:0] cfgFreq, cfgPhaseOffset;
  logic [15:0] cfgEnv;
  logic [11:0] tblAddr;
  logic        tblRdEn;
  logic [15:0] tblData;
  logic [15:0] voiceOut;
  logic [2:0]  voiceIdx;
  logic        voiceValid, frameDone, busy, overrun;

  always #5 Clk = ~Clk;

  dds_voice_engine #(.N_VOICES(NV)) dut (
    .Clk(Clk), .Reset(Reset), .sampleTick(sampleTick), .cfgWe(cfgWe),
    .cfgVoice(cfgVoice), .cfgFreq(cfgFreq), .cfgPhaseOffset(cfgPhaseOffset),
    .cfgEnv(cfgEnv), .cfgGate(cfgGate), .cfgFmEn(cfgFmEn),
    .tblAddr(tblAddr), .tblRdEn(tblRdEn), .tblData(tblData),
    .voiceOut(voiceOut), .voiceIdx(voiceIdx), .voiceValid(voiceValid),
    .frameDone(frameDone), .busy(busy), .overrun(overrun)
  );

  // External synchronous wavetable: data one cycle after the read strobe, junk otherwise.
  logic [15:0] mtbl [4096];
  always @(posedge Clk) tblData <= tblRdEn ? mtbl[tblAddr] : 16'($urandom);

  voice_cfg_t  mcfg [NV];
  logic [31:0] macc [NV];

  int checks = 0;
  int errors = 0;
  logic [15:0] got_v0_out;
  logic [11:0] got_a0, got_a1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint fdiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if (((a % b) != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic voice_cfg_t mk(input logic [31:0] f, input logic [31:0] o,
                                    input logic [15:0] e, input logic g, input logic m);
    voice_cfg_t c;
    c.freq = f; c.phaseOffset = o; c.env = e; c.gate = g; c.fmEn = m;
    return c;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      mcfg[v] = '0;
      macc[v] = '0;
    end
  endtask

  task automatic cfg_write(input int v, input voice_cfg_t c);
    cfgWe = 1'b1; cfgVoice = 3'(v);
    cfgFreq = c.freq; cfgPhaseOffset = c.phaseOffset; cfgEnv = c.env;
    cfgGate = c.gate; cfgFmEn = c.fmEn;
    @(posedge Clk); #1 cfgWe = 1'b0;
    mcfg[v] = c;
  endtask

  // Runs one frame starting with a tick in the current cycle (cycle 0).
  task automatic run_frame(input string tag, input int tick_cyc, input int wr_cyc,
                           input int wr_v, input voice_cfg_t wr_c);
    logic [11:0] exp_addr[$];
    logic [15:0] exp_out[NV];
    logic [11:0] got_addr[$];
    int          vcyc[$];
    logic [2:0]  vidx[$];
    logic [15:0] vout[$];
    logic        vfd[$];
    logic [31:0] ph;
    longint      s0, s1, fr, l, o;
    int          a, n;
    bit          applied, done;
    logic [15:0] prev;
    applied = 0; done = 0; prev = '0;
    for (int v = 0; v < NV; v++) begin
      if ((wr_cyc > 0) && (wr_v == v) && (wr_cyc <= 5 * v)) begin
        mcfg[v] = wr_c; applied = 1;
      end
      ph = macc[v] + mcfg[v].phaseOffset;
`ifdef DDS_FM_CHAIN_EN
      if ((v > 0) && mcfg[v].fmEn) ph = ph + {prev, 16'h0000};
`endif
      a  = int'(ph / 32'd1048576);
      fr = longint'((ph / 32'd16) % 32'd65536);
      s0 = longint'($signed(mtbl[a]));
      s1 = longint'($signed(mtbl[(a + 1) % 4096]));
      l  = s0 + fdiv((s1 - s0) * fr, 65536);
      o  = fdiv(l * longint'(mcfg[v].env), 65536);
      exp_out[v] = mcfg[v].gate ? 16'(o) : 16'h0000;
      prev = exp_out[v];
      exp_addr.push_back(12'(a));
      exp_addr.push_back(12'((a + 1) % 4096));
      macc[v] = mcfg[v].gate ? (macc[v] + mcfg[v].freq) : 32'h0;
    end
    if ((wr_cyc > 0) && !applied) mcfg[wr_v] = wr_c;

    sampleTick = 1'b1;
    for (int cyc = 1; cyc <= 5 * NV + 4; cyc++) begin
      @(posedge Clk); #1;
      sampleTick = (cyc == tick_cyc);
      cfgWe = (cyc == wr_cyc);
      if (cyc == wr_cyc) begin
        cfgVoice = 3'(wr_v); cfgFreq = wr_c.freq; cfgPhaseOffset = wr_c.phaseOffset;
        cfgEnv = wr_c.env; cfgGate = wr_c.gate; cfgFmEn = wr_c.fmEn;
      end
      @(negedge Clk);
      if (tblRdEn) got_addr.push_back(tblAddr);
      if (voiceValid) begin
        vcyc.push_back(cyc); vidx.push_back(voiceIdx);
        vout.push_back(voiceOut); vfd.push_back(frameDone);
        if (frameDone) done = 1;
      end
      if (done) break;
    end
    @(posedge Clk); #1 sampleTick = 1'b0; cfgWe = 1'b0;
    @(negedge Clk);
    chk({tag, " busy_after"}, busy, 1'b0);
    chk({tag, " hold_out"}, voiceOut, exp_out[NV-1]);

    chk({tag, " nvalid"}, vcyc.size(), NV);
    n = (vcyc.size() < NV) ? vcyc.size() : NV;
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s idx%0d", tag, k), vidx[k], k);
      chk($sformatf("%s out%0d", tag, k), vout[k], exp_out[k]);
      chk($sformatf("%s cyc%0d", tag, k), vcyc[k], 5 * k + 5);
      chk($sformatf("%s fd%0d", tag, k), vfd[k], (k == NV - 1));
    end
    chk({tag, " naddr"}, got_addr.size(), 2 * NV);
    n = (got_addr.size() < 2 * NV) ? got_addr.size() : 2 * NV;
    for (int k = 0; k < n; k++)
      chk($sformatf("%s addr%0d", tag, k), got_addr[k], exp_addr[k]);
    got_v0_out = (vout.size() > 0) ? vout[0] : 16'hxxxx;
    got_a0 = (got_addr.size() > 0) ? got_addr[0] : 12'hxxx;
    got_a1 = (got_addr.size() > 1) ? got_addr[1] : 12'hxxx;
  endtask

  initial begin
    int nv;
    voice_cfg_t c;
    Reset = 1'b1; sampleTick = 1'b0; cfgWe = 1'b0; cfgVoice = '0;
    cfgFreq = '0; cfgPhaseOffset = '0; cfgEnv = '0; cfgGate = 1'b0; cfgFmEn = 1'b0;
    for (int k = 0; k < 4096; k++) mtbl[k] = 16'(k * 8);
    model_reset();

    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("rst tblRdEn", tblRdEn, 1'b0);
    chk("rst tblAddr", tblAddr, 12'h0);
    chk("rst voiceValid", voiceValid, 1'b0);
    chk("rst frameDone", frameDone, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst overrun", overrun, 1'b0);
    chk("rst voiceOut", voiceOut, 16'h0);
    chk("rst voiceIdx", voiceIdx, 3'h0);
    @(posedge Clk); #1 Reset = 1'b0;

    run_frame("gate0", 0, 0, 0, '0);

    cfg_write(0, mk(32'h0010_0000, 32'h0, 16'hFFFF, 1'b1, 1'b0));
    run_frame("ramp1", 0, 0, 0, '0);
    chk("ramp1 a0", got_a0, 12'd0);
    chk("ramp1 a1", got_a1, 12'd1);
    run_frame("ramp2", 0, 0, 0, '0);
    chk("ramp2 a0", got_a0, 12'd1);
    chk("ramp2 a1", got_a1, 12'd2);
    chk("ramp2 out", got_v0_out, 16'd7);

    cfg_write(0, mk(32'h0, 32'h0, 16'hFFFF, 1'b0, 1'b0));
    run_frame("clracc", 0, 0, 0, '0);
    mtbl[0] = 16'd0; mtbl[1] = 16'd1000;
    cfg_write(0, mk(32'h0, 32'h0008_0000, 16'hFFFF, 1'b1, 1'b0));
    run_frame("frac", 0, 0, 0, '0);
    chk("frac out", got_v0_out, 16'd499);

    cfg_write(0, mk(32'h0, 32'hFFF0_0000, 16'hFFFF, 1'b1, 1'b0));
    run_frame("awrap", 0, 0, 0, '0);
    chk("awrap a0", got_a0, 12'd4095);
    chk("awrap a1", got_a1, 12'd0);

    cfg_write(0, mk(32'h8000_0000, 32'h0, 16'hFFFF, 1'b1, 1'b0));
    run_frame("accw0", 0, 0, 0, '0);
    chk("accw0 a0", got_a0, 12'd0);
    run_frame("accw1", 0, 0, 0, '0);
    chk("accw1 a0", got_a0, 12'd2048);
    run_frame("accw2", 0, 0, 0, '0);
    chk("accw2 a0", got_a0, 12'd0);

    for (int k = 0; k < 4096; k++) mtbl[k] = 16'($urandom);
    for (int v = 0; v < NV; v++)
      cfg_write(v, mk($urandom, $urandom, 16'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom)));
    run_frame("rnd0", 0, 0, 0, '0);
    c = mk($urandom, $urandom, 16'($urandom), 1'b1, 1'b1);
    run_frame("rnd_wr_v5", 0, 10, 5, c);
    c = mk($urandom, $urandom, 16'($urandom), 1'b1, 1'b0);
    run_frame("rnd_wr_inflight", 0, 7, 1, c);
    c = mk($urandom, $urandom, 16'($urandom), 1'b1, 1'b1);
    run_frame("rnd_wr_edge", 0, 5, 1, c);
    run_frame("rnd4", 0, 0, 0, '0);

    chk("ovr before", overrun, 1'b0);
    run_frame("ovr", 12, 0, 0, '0);
    chk("ovr set", overrun, 1'b1);
    repeat (10) @(negedge Clk);
    chk("ovr held", overrun, 1'b1);

    @(posedge Clk); #1 sampleTick = 1'b1;
    @(posedge Clk); #1 sampleTick = 1'b0;
    repeat (11) begin @(posedge Clk); #1; end
    Reset = 1'b1;
    @(posedge Clk); #1 Reset = 1'b0;
    nv = 0;
    repeat (50) begin @(negedge Clk); if (voiceValid) nv++; end
    chk("midrst nvalid", nv, 0);
    chk("midrst overrun", overrun, 1'b0);
    chk("midrst busy", busy, 1'b0);
    model_reset();
    @(posedge Clk); #1;
    cfg_write(0, mk(32'h0, 32'h0, 16'hFFFF, 1'b1, 1'b0));
    run_frame("postrst", 0, 0, 0, '0);
    chk("postrst a0", got_a0, 12'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dds_voice_engine.md
Name: dds_voice_engine

Overview:
- Time-multiplexed, parametrised wavetable DDS engine; successor to the single-voice oscillator.
- Each frame (one sampleTick) it runs N_VOICES voices in sequence, reading each voice's phase accumulator and per-voice config from internal register banks.
- Per voice: reads two adjacent wavetable samples from an external synchronous table, linearly interpolates, applies the envelope, and emits one output beat with the voice index.
- Feeds the FM matrix / mixer stage.

Parameters:
- P_WIDTH, 32, phase accumulator width.
- D_WIDTH, 16, signed sample/output width.
- A_WIDTH, 12, wavetable address width.
- F_WIDTH, 16, interpolation fraction width (phase bits directly below the address; requires F_WIDTH <= P_WIDTH-A_WIDTH).
- E_WIDTH, 16, unsigned envelope width.
- N_VOICES, 8, voice count (>=2).
- V_WIDTH, $clog2(N_VOICES), voice index width.

Ports:
- Clk  in  1  clock.
- Reset  in  1  synchronous, active-high reset.
- sampleTick  in  1  frame start pulse.
- cfgWe  in  1  config write strobe.
- cfgVoice  in  V_WIDTH  voice being written.
- cfgFreq  in  P_WIDTH  phase increment.
- cfgPhaseOffset  in  P_WIDTH  static phase offset.
- cfgEnv  in  E_WIDTH  envelope level.
- cfgGate  in  1  voice on.
- cfgFmEn  in  1  accept modulation from previous voice.
- tblAddr  out  A_WIDTH  wavetable address.
- tblRdEn  out  1  wavetable read strobe.
- tblData  in  D_WIDTH  signed sample; valid exactly one cycle after its tblRdEn.
- voiceOut  out  D_WIDTH  signed enveloped sample.
- voiceIdx  out  V_WIDTH  voice index of voiceOut.
- voiceValid  out  1  one-cycle output qualifier.
- frameDone  out  1  one-cycle pulse coincident with the last voice's voiceValid.
- busy  out  1  frame in progress.
- overrun  out  1  sticky: sampleTick arrived while busy.

Behaviour:
- Reset: all outputs 0; state IDLE; accumulators and config banks cleared to 0.
- FSM states: IDLE, ADDR, ADDR1, CAP, CALC, EMIT.
- 5 cycles per voice; a frame is 5*N_VOICES cycles from the cycle after sampleTick.
- IDLE:
  - sampleTick -> ADDR with voice=0; busy=1 from the next cycle.
- ADDR:
  - Latch the voice's config into working registers.
  - phase = acc[v] + phaseOffset[v] (+ modulation, see Optional Feature), mod 2^P_WIDTH.
  - addr = phase[P-1 -: A]; frac = next F_WIDTH bits.
  - Drive tblAddr=addr, tblRdEn=1.
- ADDR1:
  - tblAddr = addr+1, wrapping to 0 at 2^A-1; tblRdEn=1; s0 <= tblData.
- CAP:
  - s1 <= tblData; tblRdEn=0.
- CALC:
  - lerp = s0 + ((s1-s0)*frac >>> F_WIDTH), with the difference held in D_WIDTH+1 bits. The result stays in [s0,s1], so no saturation.
  - out = (lerp*env) >>> E_WIDTH, arithmetic shift, truncation toward -inf.
  - If gate=0, out=0.
  - Register out.
- EMIT:
  - voiceValid=1, voiceIdx=v.
  - If gate=1: acc[v] += freq[v], mod 2^P_WIDTH, wrapping silently. If gate=0: acc[v] <= 0, so note-on is phase-coherent.
  - If v==N_VOICES-1: frameDone=1 and go to IDLE. Otherwise v+1 -> ADDR.
- voiceOut holds its value between voiceValid pulses.
- Config writes:
  - Accepted every cycle.
  - A write lands in the bank on the next edge and takes effect at that voice's next ADDR.
  - A write to the voice currently in flight does not alter the in-flight computation.
  - cfgVoice >= N_VOICES: write ignored.
- sampleTick while busy: ignored, overrun set to 1 and held until Reset.
- sampleTick in the same cycle the FSM returns to IDLE is ignored. The earliest accepted tick is the cycle after frameDone.
- Reset mid-frame: abort immediately to IDLE, no further voiceValid, all state cleared.

Optional Feature:
- Macro: DDS_FM_CHAIN_EN.
- Defined: in ADDR, for v>0 with fmEn[v]=1, phase additionally adds sign-extended voiceOut(v-1, this frame) << (P_WIDTH-D_WIDTH). Full-scale modulator output therefore shifts phase by ±half cycle. Voice 0 is never modulated.
- Not defined: cfgFmEn is stored but ignored; no modulation adder is built.

Decomposition:
- Package dds_pkg:
  - state enum dds_state_t.
  - voice_cfg_t struct (freq, phaseOffset, env, gate, fmEn).
  - Default width localparams.
- Sub-module dds_lerp_env:
  - Combinational interpolation plus envelope multiply.
  - Inputs s0, s1, frac, env, gate; output out.
  - Reused later by the bilinear/multi-table variant.

Test Plan:
- Reset then one tick, all voices gate=0 -> 8 voiceValid pulses at 5-cycle spacing, idx 0..7, all voiceOut=0, frameDone with idx 7, busy falls after.
- Voice 0: freq=2^20, env=0xFFFF, gate=1, table[k]=k*8 -> tblAddr sequence 0,1 then 1,2 on the next frame. Frame-2 output = (8*0xFFFF)>>16 = 7.
- frac interpolation: offset=0x00080000 (addr 0, frac 0x8000), table[0]=0, table[1]=1000 -> lerp=500, out=(500*0xFFFF)>>16=499.
- Address wrap: offset=0xFFF00000 -> tblAddr 4095 then 0. Accumulator wrap: freq=0x80000000 over 3 frames -> phases 0, 0x80000000, 0.
- sampleTick mid-frame -> no restart, overrun=1 and held. Reset at cycle 12 of a frame -> no voiceValid after, overrun=0, accumulators 0.
- With DDS_FM_CHAIN_EN: voice 0 constant out 0x4000, voice 1 fmEn=1, freq=0 -> voice 1 reads addr 0x400. Without the macro it reads addr 0.
